// File: rtl/crop_decimate_filter.sv
// crop_decimate_filter
// Streaming region-of-interest crop with run-time X/Y decimation.
// A pending config set is written by cfg_valid and copied into the active set
// on the first accepted pixel of each frame, so a frame is always processed
// with one consistent window. The output stage is a single registered slot
// with a valid/ready handshake and SOF/EOL/EOF markers.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   cfg_valid, cfg_*        window (x1,y1,w,h) and strides (sx,sy) strobe
//   in_pixel/in_valid       raster-order input, in_ready back-pressure
//   out_pixel/out_valid     registered kept pixel, out_ready from downstream
//   out_sof/out_eol/out_eof frame/line markers, qualified by out_valid
module crop_decimate_filter #(
  parameter  int unsigned PIXEL_BIT_WIDTH = 12,
  parameter  int unsigned IN_ROWS         = 40,
  parameter  int unsigned IN_COLS         = 40,
  parameter  int unsigned MAX_STRIDE      = 4,
  localparam int unsigned CW              = $clog2(IN_COLS + 1),
  localparam int unsigned RW              = $clog2(IN_ROWS + 1),
  localparam int unsigned SW              = $clog2(MAX_STRIDE + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_valid,
  input  logic [CW-1:0]              cfg_x1,
  input  logic [RW-1:0]              cfg_y1,
  input  logic [CW-1:0]              cfg_w,
  input  logic [RW-1:0]              cfg_h,
  input  logic [SW-1:0]              cfg_sx,
  input  logic [SW-1:0]              cfg_sy,
  input  logic [PIXEL_BIT_WIDTH-1:0] in_pixel,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [PIXEL_BIT_WIDTH-1:0] out_pixel,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_sof,
  output logic                       out_eol,
  output logic                       out_eof
);

  typedef struct packed {
    logic [CW-1:0] x1;
    logic [RW-1:0] y1;
    logic [CW-1:0] w;
    logic [RW-1:0] h;
    logic [SW-1:0] sx;
    logic [SW-1:0] sy;
  } cfg_t;

  // Full-frame pass-through
  localparam cfg_t CFG_RESET = '{x1: '0, y1: '0, w: CW'(IN_COLS), h: RW'(IN_ROWS),
                                 sx: SW'(1), sy: SW'(1)};

  // Stride 0 behaves as 1, oversize strides saturate
  function automatic logic [SW-1:0] clamp_stride(input logic [SW-1:0] s);
    if (s == '0) begin
      return SW'(1);
    end else if (s > SW'(MAX_STRIDE)) begin
      return SW'(MAX_STRIDE);
    end else begin
      return s;
    end
  endfunction

  cfg_t                       r_pend;
  cfg_t                       r_act;
  logic [CW-1:0]              r_x;
  logic [RW-1:0]              r_y;
  logic [SW-1:0]              r_px;
  logic [SW-1:0]              r_py;
  logic [PIXEL_BIT_WIDTH-1:0] r_out_pixel;
  logic                       r_out_valid;
  logic                       r_out_sof;
  logic                       r_out_eol;
  logic                       r_out_eof;

  cfg_t          w_cfg_in;
  cfg_t          w_cfg;
  logic          w_acc;
  logic          w_frame_start;
  logic          w_row_end;
  logic [SW-1:0] w_sx;
  logic [SW-1:0] w_sy;
  logic [CW:0]   w_x_end;
  logic [RW:0]   w_y_end;
  logic          w_in_x;
  logic          w_in_y;
  logic [SW-1:0] w_px_cur;
  logic [SW-1:0] w_py_cur;
  logic [SW-1:0] w_px_inc;
  logic [SW-1:0] w_py_inc;
  logic [SW-1:0] w_px_nxt;
  logic [SW-1:0] w_py_nxt;
  logic          w_keep;
  logic          w_sof;
  logic          w_eol;
  logic          w_eof;

  assign w_cfg_in = '{x1: cfg_x1, y1: cfg_y1, w: cfg_w, h: cfg_h, sx: cfg_sx, sy: cfg_sy};

  assign in_ready      = !r_out_valid || out_ready;
  assign w_acc         = in_valid && in_ready;
  assign w_frame_start = (r_x == '0) && (r_y == '0);
  assign w_row_end     = (r_x == CW'(IN_COLS - 1));

  // The pixel at (0,0) already sees the config that loads on its accept
  assign w_cfg = w_frame_start ? r_pend : r_act;
  assign w_sx  = clamp_stride(w_cfg.sx);
  assign w_sy  = clamp_stride(w_cfg.sy);

  // Window bounds in one extra bit so x1+w cannot wrap
  assign w_x_end = {1'b0, w_cfg.x1} + {1'b0, w_cfg.w};
  assign w_y_end = {1'b0, w_cfg.y1} + {1'b0, w_cfg.h};
  assign w_in_x  = (r_x >= w_cfg.x1) && ({1'b0, r_x} < w_x_end);
  assign w_in_y  = (r_y >= w_cfg.y1) && ({1'b0, r_y} < w_y_end);

  // Phase restarts at the window origin, then wraps at the stride
  assign w_px_cur = (r_x == w_cfg.x1) ? '0 : r_px;
  assign w_py_cur = (r_y == w_cfg.y1) ? '0 : r_py;
  assign w_px_inc = w_px_cur + SW'(1);
  assign w_py_inc = w_py_cur + SW'(1);
  assign w_px_nxt = (w_px_inc == w_sx) ? '0 : w_px_inc;
  assign w_py_nxt = (w_py_inc == w_sy) ? '0 : w_py_inc;

  assign w_keep = w_in_x && w_in_y && (w_px_cur == '0) && (w_py_cur == '0);

  // Markers look one stride ahead against the window edge or the image edge
  assign w_sof = (r_x == w_cfg.x1) && (r_y == w_cfg.y1);
  assign w_eol = (({1'b0, r_x} + (CW+1)'(w_sx)) >= w_x_end) || w_row_end;
  assign w_eof = w_eol && ((({1'b0, r_y} + (RW+1)'(w_sy)) >= w_y_end) ||
                           (r_y == RW'(IN_ROWS - 1)));

  // Config, raster/phase counters and output slot
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend      <= CFG_RESET;
      r_act       <= CFG_RESET;
      r_x         <= '0;
      r_y         <= '0;
      r_px        <= '0;
      r_py        <= '0;
      r_out_pixel <= '0;
      r_out_valid <= 1'b0;
      r_out_sof   <= 1'b0;
      r_out_eol   <= 1'b0;
      r_out_eof   <= 1'b0;
    end else begin
      if (cfg_valid) begin
        r_pend <= w_cfg_in;
      end

      if (w_acc) begin
        if (w_frame_start) begin
          r_act <= r_pend;
        end
        if (w_in_x) begin
          r_px <= w_px_nxt;
        end
        if (w_row_end) begin
          r_x <= '0;
          if (w_in_y) begin
            r_py <= w_py_nxt;
          end
          if (r_y == RW'(IN_ROWS - 1)) begin
            r_y <= '0;
          end else begin
            r_y <= r_y + RW'(1);
          end
        end else begin
          r_x <= r_x + CW'(1);
        end
      end

      if (w_acc && w_keep) begin
        r_out_pixel <= in_pixel;
        r_out_valid <= 1'b1;
        r_out_sof   <= w_sof;
        r_out_eol   <= w_eol;
        r_out_eof   <= w_eof;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_pixel = r_out_pixel;
  assign out_valid = r_out_valid;
  assign out_sof   = r_out_sof;
  assign out_eol   = r_out_eol;
  assign out_eof   = r_out_eof;

endmodule

// File: doc/crop_decimate_filter.md
# crop_decimate_filter

Streaming region-of-interest crop with integer decimation, placed between the camera grabber and downstream pixel processing. It replaces the fixed compile-time crop with a crop window and X/Y strides that are programmed at run time. New settings take effect only on a frame boundary. The output is registered with a full valid/ready handshake and carries start-of-frame, end-of-line and end-of-frame markers.

## Interface
- PIXEL_BIT_WIDTH, 12, pixel data width
- IN_ROWS, 40, input frame height
- IN_COLS, 40, input frame width
- MAX_STRIDE, 4, largest decimation factor; stride ports are SW = $clog2(MAX_STRIDE+1) bits
- CW = $clog2(IN_COLS+1), RW = $clog2(IN_ROWS+1) (derived widths, not overridable)

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- cfg_valid  in  1  one-cycle strobe; captures cfg_* into the pending registers
- cfg_x1  in  CW  window left column
- cfg_y1  in  RW  window top row
- cfg_w  in  CW  window width in input pixels
- cfg_h  in  RW  window height in input pixels
- cfg_sx  in  SW  column stride
- cfg_sy  in  SW  row stride
- in_pixel  in  PIXEL_BIT_WIDTH  raster-order input pixel
- in_valid  in  1  in_pixel valid
- in_ready  out  1  block can accept a pixel this cycle
- out_pixel  out  PIXEL_BIT_WIDTH  output pixel
- out_valid  out  1  out_pixel valid
- out_ready  in  1  downstream accepts
- out_sof  out  1  first kept pixel of frame; qualified by out_valid
- out_eol  out  1  last kept pixel of output row; qualified by out_valid
- out_eof  out  1  last kept pixel of frame; qualified by out_valid

## Operation
- Input accept: acc = in_valid && in_ready, where in_ready = !out_valid || out_ready (combinational).
- Raster counters: x counts 0..IN_COLS-1 and y counts 0..IN_ROWS-1, both advancing on acc.
  - When x reaches IN_COLS-1 it wraps to 0 and y increments.
  - When y reaches IN_ROWS-1 at that wrap, y also wraps to 0.
- Config registers:
  - cfg_valid writes the pending set. A second cfg_valid before the frame boundary overwrites the first (last write wins).
  - The active set loads from the pending set on any acc with x==0 and y==0 (frame start). The pixel accepted on that same cycle is evaluated with the newly loaded values.
- Stride rule: a stride value of 0 is treated as 1. Values above MAX_STRIDE are clamped to MAX_STRIDE.
- Phase counters: px and py count the offset since the last kept column and row.
  - px resets to 0 at x==x1 and advances modulo sx while inside the window.
  - py behaves the same way for rows.
  - No divider or modulo operator in RTL.
- Keep condition:
  - x in [x1, x1+w) and y in [y1, y1+h), and px==0 and py==0.
  - The window is clipped at the image edge.
  - If w==0, h==0, x1>=IN_COLS or y1>=IN_ROWS, nothing is kept for that frame.
- Kept pixel: on acc, out_pixel is loaded with in_pixel and out_valid is set. Dropped pixels are still consumed but produce no output.
- Marker definitions, each computed in at least CW+1 / RW+1 bits so the sums do not overflow:
  - sof = (x==x1 && y==y1).
  - eol = (x+sx >= x1+w) or x==IN_COLS-1.
  - eof = eol && ((y+sy >= y1+h) or y==IN_ROWS-1).
- Output register:
  - out_valid clears when out_valid && out_ready and no new kept pixel is accepted that cycle.
  - Simultaneous drain and new kept accept: out_valid stays 1 and the register takes the new pixel.

## Timing
- Reset values:
  - Outputs: out_valid=0, out_sof=0, out_eol=0, out_eof=0, out_pixel=0.
  - Counters: x=0, y=0, px=0, py=0.
  - Active and pending config: x1=0, y1=0, w=IN_COLS, h=IN_ROWS, sx=1, sy=1 (pass-through).
- in_ready is 1 in the cycle after reset.
- Latency: a kept pixel accepted at edge N is presented with out_valid=1 after edge N, i.e. 1 cycle.
- Stall: while out_valid && !out_ready, out_pixel and all markers hold stable, in_ready=0, and the counters freeze.
- Throughput: one pixel per cycle when out_ready is held high.
- Reset mid-frame: the in-flight output is discarded, counters return to 0 and config returns to pass-through. The next accepted pixel is treated as (0,0).
- cfg_valid mid-frame has no effect on the current frame.

## Test plan
- After reset, pass-through: stream 1600 pixels with value = index and out_ready=1 → 1600 outputs equal to the input.
  - out_sof on index 0.
  - out_eol on every 40th output.
  - out_eof on index 1599.
- Crop x1=10, y1=10, w=20, h=20, stride 1 → 400 outputs, first 410, last 1189.
  - out_eol on column 29.
- Same window with sx=2, sy=2 → 100 outputs; rows 10,12,…,28; columns 10,12,…,28.
  - First output 410, last 1148.
- Backpressure: random out_ready at 50% duty during the crop case → identical output sequence, and out_pixel is stable across every stalled cycle.
- Mid-frame cfg_valid: program a crop at pixel 700 → the current frame stays full pass-through and the crop applies from the next frame's pixel (0,0).
- Edge clip: x1=30, w=20, sx=3 → kept columns 30, 33, 36, 39, with out_eol on column 39.
  - Also assert reset at pixel 500, then verify the pass-through frame restarts cleanly.
